// File: rtl/hazard_forward_unit_if.sv
// Bundle between the decode/execute stages and the hazard/forwarding unit.
// The master side (pipeline) presents the decoded ID instruction and the
// EX branch outcome. The slave side (hazard unit) returns the operand
// selects and the pipeline control strobes.
interface hazard_forward_unit_if #(
   parameter int REG_ADDR_W = 3
);
   // Decoded instruction currently in ID
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   // Branch resolution from EX
   logic                  ex_branch_taken;
   // Registered operand selects, valid while the instruction is in EX
   logic [1:0]            forward_a;
   logic [1:0]            forward_b;
   logic [1:0]            forward_al;
   logic [1:0]            forward_bl;
   logic                  result_src_mem;
   // Pipeline control, combinational from current state and inputs
   logic                  stall_if_id;
   logic                  bubble_id_ex;
   logic                  flush_if_id;
   logic                  flush_id_ex;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
             ex_branch_taken,
      input  forward_a, forward_b, forward_al, forward_bl, result_src_mem,
             stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
             ex_branch_taken,
      output forward_a, forward_b, forward_al, forward_bl, result_src_mem,
             stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 8-bit pipelined core.
// Tracks the destinations of the instructions in EX and MEM, registers the
// operand selects for the instruction entering EX, and raises load-use
// stalls and taken-branch flushes through a three-state controller.
// A producer that has reached WB is not tracked: the register file is
// write-through, so the ID read already sees that value.
module hazard_forward_unit #(
   parameter int REG_ADDR_W   = 3,
   parameter int FLUSH_CYCLES = 2,
   parameter int ZERO_REG_EN  = 1
) (
   input logic                  clk,
   input logic                  reset,
   hazard_forward_unit_if.slave hif
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } entry_t;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2
   } state_t;

   localparam entry_t ENTRY_EMPTY = '{valid: 1'b0, rd: {REG_ADDR_W{1'b0}},
                                      reg_write: 1'b0, mem_read: 1'b0};
   // Cycles spent in ST_FLUSH after the branch cycle itself
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   // With a one-cycle flush the branch cycle alone covers it
   localparam bit USE_FLUSH_ST = (FLUSH_CYCLES > 1);

   // True when entry e will supply the value of source register s
   function automatic logic producer_match(input entry_t e,
                                           input logic [REG_ADDR_W-1:0] s);
      logic zero_src;
      zero_src = (ZERO_REG_EN != 0) && (s == {REG_ADDR_W{1'b0}});
      return e.valid && e.reg_write && (e.rd == s) && !zero_src;
   endfunction

   // Returns {producer_is_load, select}; the younger EX producer wins
   function automatic logic [2:0] fwd_select(input logic [REG_ADDR_W-1:0] s,
                                             input entry_t ex_e,
                                             input entry_t mem_e);
      logic [2:0] sel;
      if (producer_match(ex_e, s)) begin
         sel = {ex_e.mem_read, 2'b10};
      end else if (producer_match(mem_e, s)) begin
         sel = {mem_e.mem_read, 2'b01};
      end else begin
         sel = 3'b000;
      end
      return sel;
   endfunction

   entry_t     ex_e_r;
   entry_t     mem_e_r;
   state_t     state_r;
   logic [2:0] cnt_r;
   logic [1:0] fwd_a_r;
   logic [1:0] fwd_b_r;
   logic [1:0] fwd_al_r;
   logic [1:0] fwd_bl_r;
   logic       rsm_r;

   logic [2:0] sel_a_s;
   logic [2:0] sel_b_s;
   logic       load_use_s;
   logic       flush_s;
   logic       stall_s;
   logic       capture_s;
   entry_t     id_e_s;

   // Hazard detection and forward-select computation for the ID instruction
   always_comb begin
      sel_a_s    = 3'b000;
      sel_b_s    = 3'b000;
      load_use_s = 1'b0;
      flush_s    = 1'b0;
      stall_s    = 1'b0;
      capture_s  = 1'b0;
      id_e_s     = '{valid: hif.id_valid, rd: hif.id_rd,
                     reg_write: hif.id_reg_write, mem_read: hif.id_mem_read};

      sel_a_s = fwd_select(hif.id_rs1, ex_e_r, mem_e_r);
      sel_b_s = fwd_select(hif.id_rs2, ex_e_r, mem_e_r);

      if ((state_r == ST_RUN) && hif.id_valid && ex_e_r.mem_read &&
          (producer_match(ex_e_r, hif.id_rs1) ||
           producer_match(ex_e_r, hif.id_rs2))) begin
         load_use_s = 1'b1;
      end else begin
         load_use_s = 1'b0;
      end

      if (reset) begin
         flush_s = 1'b0;
         stall_s = 1'b0;
      end else begin
         flush_s = hif.ex_branch_taken || (state_r == ST_FLUSH);
         // A taken branch squashes the consumer, so no stall is needed
         stall_s = load_use_s && !flush_s;
      end

      capture_s = hif.id_valid && !flush_s && !stall_s;
   end

   // Stage tracking and registered operand selects, advanced every edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_e_r   <= ENTRY_EMPTY;
         mem_e_r  <= ENTRY_EMPTY;
         fwd_a_r  <= 2'b00;
         fwd_b_r  <= 2'b00;
         fwd_al_r <= 2'b00;
         fwd_bl_r <= 2'b00;
         rsm_r    <= 1'b0;
      end else begin
         mem_e_r <= ex_e_r;
         if (capture_s) begin
            ex_e_r   <= id_e_s;
            fwd_a_r  <= sel_a_s[2] ? 2'b00 : sel_a_s[1:0];
            fwd_al_r <= sel_a_s[2] ? sel_a_s[1:0] : 2'b00;
            fwd_b_r  <= sel_b_s[2] ? 2'b00 : sel_b_s[1:0];
            fwd_bl_r <= sel_b_s[2] ? sel_b_s[1:0] : 2'b00;
            rsm_r    <= sel_a_s[2] | sel_b_s[2];
         end else begin
            // Bubble, squashed or stalled slot: nothing to forward
            ex_e_r   <= ENTRY_EMPTY;
            fwd_a_r  <= 2'b00;
            fwd_b_r  <= 2'b00;
            fwd_al_r <= 2'b00;
            fwd_bl_r <= 2'b00;
            rsm_r    <= 1'b0;
         end
      end
   end

   // Run / load-stall / flush controller with the flush down-counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_RUN;
         cnt_r   <= 3'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (hif.ex_branch_taken) begin
                  state_r <= USE_FLUSH_ST ? ST_FLUSH : ST_RUN;
                  cnt_r   <= USE_FLUSH_ST ? FLUSH_LOAD : 3'd0;
               end else if (load_use_s) begin
                  state_r <= ST_LOAD_STALL;
                  cnt_r   <= 3'd0;
               end else begin
                  state_r <= ST_RUN;
                  cnt_r   <= 3'd0;
               end
            end
            ST_LOAD_STALL: begin
               if (hif.ex_branch_taken) begin
                  state_r <= USE_FLUSH_ST ? ST_FLUSH : ST_RUN;
                  cnt_r   <= USE_FLUSH_ST ? FLUSH_LOAD : 3'd0;
               end else begin
                  state_r <= ST_RUN;
                  cnt_r   <= 3'd0;
               end
            end
            ST_FLUSH: begin
               if (hif.ex_branch_taken) begin
                  state_r <= ST_FLUSH;
                  cnt_r   <= FLUSH_LOAD;
               end else if (cnt_r <= 3'd1) begin
                  state_r <= ST_RUN;
                  cnt_r   <= 3'd0;
               end else begin
                  state_r <= ST_FLUSH;
                  cnt_r   <= cnt_r - 3'd1;
               end
            end
            default: begin
               state_r <= ST_RUN;
               cnt_r   <= 3'd0;
            end
         endcase
      end
   end

   assign hif.forward_a      = fwd_a_r;
   assign hif.forward_b      = fwd_b_r;
   assign hif.forward_al     = fwd_al_r;
   assign hif.forward_bl     = fwd_bl_r;
   assign hif.result_src_mem = rsm_r;
   assign hif.stall_if_id    = stall_s;
   assign hif.bubble_id_ex   = stall_s;
   assign hif.flush_if_id    = flush_s;
   assign hif.flush_id_ex    = flush_s;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. Each cycle the stimulus process
// drives one ID vector and queues the outputs expected during that cycle;
// a monitor process pops and compares on the falling edge.
module tb_hazard_forward_unit;

   logic clk;
   logic reset;

   hazard_forward_unit_if #(.REG_ADDR_W(3)) hif ();

   hazard_forward_unit #(
      .REG_ADDR_W  (3),
      .FLUSH_CYCLES(2),
      .ZERO_REG_EN (1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hif  (hif)
   );

   typedef struct {
      int         idx;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [1:0] fal;
      logic [1:0] fbl;
      logic       rsm;
      logic       stall;
      logic       fl;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int idx, input string name,
                      input logic [1:0] act, input logic [1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL cycle %0d %s: got %b expected %b", idx, name, act, req);
      end
   endtask

   // One stimulus cycle: drive ID/branch/reset, queue the expected outputs
   task automatic put(input logic rst, input logic v, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic rw, input logic mr, input logic br,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [1:0] fal, input logic [1:0] fbl,
                      input logic rsm, input logic stall, input logic fl);
      exp_t e;
      @(posedge clk);
      #1;
      reset               = rst;
      hif.id_valid        = v;
      hif.id_rd           = rd;
      hif.id_rs1          = rs1;
      hif.id_rs2          = rs2;
      hif.id_reg_write    = rw;
      hif.id_mem_read     = mr;
      hif.ex_branch_taken = br;
      e.idx   = cyc;
      e.fa    = fa;
      e.fb    = fb;
      e.fal   = fal;
      e.fbl   = fbl;
      e.rsm   = rsm;
      e.stall = stall;
      e.fl    = fl;
      exp_q.push_back(e);
      cyc++;
   endtask

   // Monitor: compare every presented cycle against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.idx, "forward_a",      hif.forward_a,  e.fa);
            chk(e.idx, "forward_b",      hif.forward_b,  e.fb);
            chk(e.idx, "forward_al",     hif.forward_al, e.fal);
            chk(e.idx, "forward_bl",     hif.forward_bl, e.fbl);
            chk(e.idx, "result_src_mem", {1'b0, hif.result_src_mem}, {1'b0, e.rsm});
            chk(e.idx, "stall_if_id",    {1'b0, hif.stall_if_id},    {1'b0, e.stall});
            chk(e.idx, "bubble_id_ex",   {1'b0, hif.bubble_id_ex},   {1'b0, e.stall});
            chk(e.idx, "flush_if_id",    {1'b0, hif.flush_if_id},    {1'b0, e.fl});
            chk(e.idx, "flush_id_ex",    {1'b0, hif.flush_id_ex},    {1'b0, e.fl});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset               = 1'b1;
      hif.id_valid        = 1'b0;
      hif.id_rd           = 3'd0;
      hif.id_rs1          = 3'd0;
      hif.id_rs2          = 3'd0;
      hif.id_reg_write    = 1'b0;
      hif.id_mem_read     = 1'b0;
      hif.ex_branch_taken = 1'b0;

      //  rst v  rd    rs1   rs2   rw mr br | fa    fb    fal   fbl   rsm stall fl
      // reset state
      put(1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I0 writes r1
      put(0, 1, 3'd1, 3'd5, 3'd6, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I1 writes r2, reads r1 back-to-back
      put(0, 1, 3'd2, 3'd1, 3'd7, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I2 writes r3, reads r1 on rs2 at distance 2; I1 now in EX: fa=10
      put(0, 1, 3'd3, 3'd4, 3'd1, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I3 also writes r3; I2 in EX: fb=01
      put(0, 1, 3'd3, 3'd6, 3'd7, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
      // I4 reads r3 (both producers write it), r2 is in WB
      put(0, 1, 3'd6, 3'd3, 3'd2, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I5 writes r0; I4 in EX: younger wins, fa=10
      put(0, 1, 3'd0, 3'd7, 3'd7, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I6 reads r0 on both sources: no forwarding
      put(0, 1, 3'd1, 3'd0, 3'd0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I7 load r4, reads r1 produced by I6
      put(0, 1, 3'd4, 3'd1, 3'd0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I8 reads r4 right behind the load: load-use stall; I7 in EX fa=10
      put(0, 1, 3'd5, 3'd4, 3'd1, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1, 0);
      // I8 held in ID; bubble in EX, no second stall
      put(0, 1, 3'd5, 3'd4, 3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // ID bubble; I8 in EX takes load data from WB
      put(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 0);
      // Branch taken; I10 would forward r5 from MEM but is squashed
      put(0, 1, 3'd2, 3'd5, 3'd0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
      // Second flush cycle; I11 (writes r3) squashed
      put(0, 1, 3'd3, 3'd5, 3'd0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
      // Back in RUN; squashed writers of r2/r3 must not forward
      put(0, 1, 3'd6, 3'd2, 3'd3, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // I13 load r7
      put(0, 1, 3'd7, 3'd0, 3'd0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // Load-use coincident with taken branch: flush only
      put(0, 1, 3'd1, 3'd7, 3'd0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
      // Branch again while flushing: reload; load r7 in MEM but squashed
      put(0, 1, 3'd1, 3'd7, 3'd7, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
      // Reloaded counter keeps flush high one more cycle
      put(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
      // New branch from RUN
      put(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
      // Reset asserted mid-flush, branch still high: all outputs low
      put(1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      // After reset: state RUN, no flush
      put(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      put(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() > 0) begin
            @(negedge clk);
         end
      end
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
